fx1_addsub_pipe: RTL and testbench

Pipelined SIMD add/subtract unit for the FX1 (simple fixed-point) execution path. Performs word and halfword add, add-immediate, subtract-from and subtract-from-immediate across a DATA_W-bit vector register, with optional carry/borrow generate. Issues one operation per cycle with a fixed STAGES-cycle latency, carrying the destination register tag alongside the result for writeback. Supports a synchronous pipeline flush.

---
 rtl/fx1_addsub_pipe.sv | 139 +++++++++++++
 tb/tb_fx1_addsub_pipe.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fx1_addsub_pipe.sv
// fx1_addsub_pipe: pipelined SIMD word/halfword add and subtract for the FX1
// fixed-point path. One issue per cycle, fixed STAGES-cycle latency, tag carried
// alongside the result. Build option: define FX1_CARRY_EN to add the cg/bg
// (carry generate / borrow generate) word ops; without it those codes give zero.
module fx1_addsub_pipe #(
   parameter int STAGES = 2,
   parameter int DATA_W = 128,
   parameter int TAG_W  = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [0:3]        op,
   input  logic [0:DATA_W-1] ra,
   input  logic [0:DATA_W-1] rb,
   input  logic [0:9]        imme,
   input  logic [0:TAG_W-1]  rt_in,
   input  logic              flush,
   output logic              out_valid,
   output logic [0:DATA_W-1] result,
   output logic [0:TAG_W-1]  rt_out
);

   localparam int NSLOT = DATA_W / 32;

   localparam logic [3:0] OP_A    = 4'b0000;
   localparam logic [3:0] OP_AI   = 4'b0001;
   localparam logic [3:0] OP_AH   = 4'b0010;
   localparam logic [3:0] OP_AHI  = 4'b0011;
   localparam logic [3:0] OP_SF   = 4'b0100;
   localparam logic [3:0] OP_SFI  = 4'b0101;
   localparam logic [3:0] OP_SFH  = 4'b0110;
   localparam logic [3:0] OP_SFHI = 4'b0111;
`ifdef FX1_CARRY_EN
   localparam logic [3:0] OP_CG   = 4'b1000;
   localparam logic [3:0] OP_BG   = 4'b1001;
`endif

   // Immediate is shared by every slot; imme[0] is its sign bit.
   logic [31:0]       w_imm32;
   logic [15:0]       w_imm16;
   logic [0:DATA_W-1] w_result;

   assign w_imm32 = {{22{imme[0]}}, imme};
   assign w_imm16 = {{6{imme[0]}}, imme};

   // One independent 32-bit lane per word slot; halfword ops split the lane in
   // two so no carry crosses from the low halfword into the high one.
   genvar gi;
   generate
      for (gi = 0; gi < NSLOT; gi++) begin : g_slot
         logic [31:0] w_a;
         logic [31:0] w_b;
         logic [31:0] w_res;
         logic [15:0] w_ah;
         logic [15:0] w_al;
         logic [15:0] w_bh;
         logic [15:0] w_bl;

         assign w_a  = ra[32*gi +: 32];
         assign w_b  = rb[32*gi +: 32];
         assign w_ah = w_a[31:16];
         assign w_al = w_a[15:0];
         assign w_bh = w_b[31:16];
         assign w_bl = w_b[15:0];

`ifdef FX1_CARRY_EN
         logic [32:0] w_add33;
         logic        w_cg;
         logic        w_bg;

         assign w_add33 = {1'b0, w_a} + {1'b0, w_b};
         assign w_cg    = (w_add33 >= 33'h1_0000_0000);
         assign w_bg    = (w_b >= w_a);
`endif

         // Per-slot operation select; unknown codes yield zero.
         always_comb begin
            w_res = '0;
            case (op)
               OP_A:    w_res = w_a + w_b;
               OP_AI:   w_res = w_a + w_imm32;
               OP_AH:   w_res = {w_ah + w_bh, w_al + w_bl};
               OP_AHI:  w_res = {w_ah + w_imm16, w_al + w_imm16};
               OP_SF:   w_res = w_b + ~w_a + 32'd1;
               OP_SFI:  w_res = w_imm32 + ~w_a + 32'd1;
               OP_SFH:  w_res = {w_bh + ~w_ah + 16'd1, w_bl + ~w_al + 16'd1};
               OP_SFHI: w_res = {w_imm16 + ~w_ah + 16'd1, w_imm16 + ~w_al + 16'd1};
`ifdef FX1_CARRY_EN
               OP_CG:   w_res = {31'd0, w_cg};
               OP_BG:   w_res = {31'd0, w_bg};
`endif
               default: w_res = '0;
            endcase
         end

         assign w_result[32*gi +: 32] = w_res;
      end
   endgenerate

   // Stage 0 captures the computed vector; later stages only delay it.
   logic [0:DATA_W-1] r_data [STAGES];
   logic [0:TAG_W-1]  r_tag  [STAGES];
   logic              r_vld  [STAGES];

   // Pipeline advance: reset wins, flush kills all valids and blocks data loads
   // so the outputs hold; otherwise each stage loads only when its source is valid.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int s = 0; s < STAGES; s++) begin
            r_vld[s]  <= 1'b0;
            r_data[s] <= '0;
            r_tag[s]  <= '0;
         end
      end else if (flush) begin
         for (int s = 0; s < STAGES; s++) begin
            r_vld[s] <= 1'b0;
         end
      end else begin
         r_vld[0] <= in_valid;
         if (in_valid) begin
            r_data[0] <= w_result;
            r_tag[0]  <= rt_in;
         end
         for (int s = 1; s < STAGES; s++) begin
            r_vld[s] <= r_vld[s-1];
            if (r_vld[s-1]) begin
               r_data[s] <= r_data[s-1];
               r_tag[s]  <= r_tag[s-1];
            end
         end
      end
   end

   assign out_valid = r_vld[STAGES-1];
   assign result    = r_data[STAGES-1];
   assign rt_out    = r_tag[STAGES-1];

endmodule

// File: tb/tb_fx1_addsub_pipe.sv
// tb_fx1_addsub_pipe: table vectors, directed flush/reset sequences and random
// traffic for fx1_addsub_pipe, scored against a slot-arithmetic reference model.
module tb_fx1_addsub_pipe;

   localparam int STAGES = 2;
   localparam int DW     = 128;
   localparam int TW     = 7;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic [0:3]    op = '0;
   logic [0:DW-1] ra = '0;
   logic [0:DW-1] rb = '0;
   logic [0:9]    imme = '0;
   logic [0:TW-1] rt_in = '0;
   logic          flush = 1'b0;
   logic          out_valid;
   logic [0:DW-1] result;
   logic [0:TW-1] rt_out;

   fx1_addsub_pipe #(.STAGES(STAGES), .DATA_W(DW), .TAG_W(TW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op(op), .ra(ra), .rb(rb),
      .imme(imme), .rt_in(rt_in), .flush(flush), .out_valid(out_valid),
      .result(result), .rt_out(rt_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            due;
      logic [0:DW-1] data;
      logic [0:TW-1] tag;
   } exp_t;

   typedef struct {
      string         name;
      logic [0:3]    op;
      logic [0:DW-1] a;
      logic [0:DW-1] b;
      logic [0:9]    im;
      logic [0:DW-1] exp;
   } vec_t;

   exp_t          sb[$];
   int            edge_cnt = 0;
   int            checks = 0;
   int            failures = 0;
   int            emitted = 0;
   logic [0:DW-1] last_res = '0;
   logic [0:TW-1] last_tag = '0;

`ifdef FX1_CARRY_EN
   localparam logic [31:0] CG_ONE = 32'h0000_0001;
`else
   localparam logic [31:0] CG_ONE = 32'h0000_0000;
`endif

   // Reference: plain integer arithmetic per slot, wrapped by truncation.
   function automatic logic [0:DW-1] model(input logic [0:3] o, input logic [0:DW-1] a,
                                           input logic [0:DW-1] b, input logic [0:9] im);
      logic [0:DW-1] r;
      longint        imv, x, y, v;
      int            oc;
      r   = '0;
      oc  = int'(o);
      imv = im[0] ? longint'(im) - 1024 : longint'(im);
      if (oc == 0 || oc == 1 || oc == 4 || oc == 5 || oc == 8 || oc == 9) begin
         for (int s = 0; s < DW/32; s++) begin
            x = longint'(a[32*s +: 32]);
            y = longint'(b[32*s +: 32]);
            v = 0;
            case (oc)
               0: v = x + y;
               1: v = x + imv;
               4: v = y - x;
               5: v = imv - x;
`ifdef FX1_CARRY_EN
               8: v = (x + y >= 64'h1_0000_0000) ? 1 : 0;
               9: v = (y >= x) ? 1 : 0;
`endif
               default: v = 0;
            endcase
            r[32*s +: 32] = v[31:0];
         end
      end else if (oc >= 2 && oc <= 7) begin
         for (int h = 0; h < DW/16; h++) begin
            x = longint'(a[16*h +: 16]);
            y = longint'(b[16*h +: 16]);
            case (oc)
               2: v = x + y;
               3: v = x + imv;
               6: v = y - x;
               default: v = imv - x;
            endcase
            r[16*h +: 16] = v[15:0];
         end
      end
      return r;
   endfunction

   // One clock: drive, take the edge, update expectations, compare outputs.
   task automatic step(input string nm, input bit v, input logic [0:3] o,
                       input logic [0:DW-1] a, input logic [0:DW-1] b, input logic [0:9] im,
                       input logic [0:TW-1] t, input bit fl, input bit rs,
                       input logic [0:DW-1] expd);
      exp_t e;
      in_valid = v; op = o; ra = a; rb = b; imme = im; rt_in = t;
      flush = fl; rst_n = ~rs;
      @(posedge clk);
      edge_cnt++;
      if (rs || fl) sb.delete();
      if (rs) begin
         last_res = '0;
         last_tag = '0;
      end
      if (v && !fl && !rs) begin
         e.due = edge_cnt + STAGES - 1; e.data = expd; e.tag = t;
         sb.push_back(e);
      end
      #1;
      checks++;
      if (sb.size() > 0 && sb[0].due == edge_cnt) begin
         e = sb.pop_front();
         emitted++;
         if (!(out_valid === 1'b1 && result === e.data && rt_out === e.tag)) begin
            failures++;
            $display("FAIL %s edge=%0d: got v=%b res=%h tag=%h, want v=1 res=%h tag=%h",
                     nm, edge_cnt, out_valid, result, rt_out, e.data, e.tag);
         end
         last_res = e.data;
         last_tag = e.tag;
      end else begin
         if (!(out_valid === 1'b0 && result === last_res && rt_out === last_tag)) begin
            failures++;
            $display("FAIL %s idle edge=%0d: got v=%b res=%h tag=%h, want v=0 res=%h tag=%h",
                     nm, edge_cnt, out_valid, result, rt_out, last_res, last_tag);
         end
      end
      $display("edge=%0d %s in_v=%b op=%h fl=%b rst=%b -> out_v=%b res=%h tag=%h",
               edge_cnt, nm, v, o, fl, rs, out_valid, result, rt_out);
      in_valid = 1'b0; flush = 1'b0; rst_n = 1'b1;
   endtask

   task automatic idle(input string nm, input int n);
      for (int i = 0; i < n; i++) step(nm, 1'b0, 4'h0, '0, '0, '0, '0, 1'b0, 1'b0, '0);
   endtask

   task automatic count_check(input string nm, input int want);
      checks++;
      if (emitted != want) begin
         failures++;
         $display("FAIL %s: emitted=%0d want=%0d", nm, emitted, want);
      end
   endtask

   vec_t          tbl [13];
   logic [0:DW-1] ra_r, rb_r;
   logic [0:3]    op_r;
   logic [0:9]    im_r;
   int            want;

   initial begin
      tbl[0]  = '{"ai_m1",    4'h1, {4{32'h0000_0005}}, '0, 10'h3FF, {4{32'h0000_0004}}};
      tbl[1]  = '{"ai_p511",  4'h1, {4{32'h0000_0001}}, '0, 10'h1FF, {4{32'h0000_0200}}};
      tbl[2]  = '{"ahi_wrap", 4'h3, {8{16'h7FFF}},      '0, 10'h001, {8{16'h8000}}};
      tbl[3]  = '{"ahi_ffff", 4'h3, {8{16'hFFFF}},      '0, 10'h001, '0};
      tbl[4]  = '{"ah_nocry", 4'h2, {4{32'h0001_FFFF}}, {4{32'h0000_0001}}, 10'h0, {4{32'h0001_0000}}};
      tbl[5]  = '{"a_wrap",   4'h0, {4{32'hFFFF_FFFF}}, {4{32'h0000_0001}}, 10'h0, '0};
      tbl[6]  = '{"sfi",      4'h5, {4{32'h0000_0003}}, '0, 10'h00A, {4{32'h0000_0007}}};
      tbl[7]  = '{"sf_neg",   4'h4, {4{32'h0000_0003}}, {4{32'h0000_0002}}, 10'h0, {4{32'hFFFF_FFFF}}};
      tbl[8]  = '{"sfh",      4'h6, {4{32'h0002_0001}}, {4{32'h0001_0002}}, 10'h0, {4{32'hFFFF_0001}}};
      tbl[9]  = '{"sfhi",     4'h7, {4{32'h0001_0005}}, '0, 10'h3FE, {4{32'hFFFD_FFF9}}};
      tbl[10] = '{"illegal",  4'hF, {4{32'h1234_5678}}, {4{32'h1111_1111}}, 10'h155, '0};
      tbl[11] = '{"cg",       4'h8, {4{32'hFFFF_FFFF}}, {4{32'h0000_0001}}, 10'h0, {4{CG_ONE}}};
      tbl[12] = '{"bg_lt",    4'h9, {4{32'h0000_0005}}, {4{32'h0000_0004}}, 10'h0, '0};

      // Reset state.
      step("reset", 1'b0, 4'h0, '0, '0, '0, '0, 1'b0, 1'b1, '0);
      step("reset", 1'b0, 4'h0, '0, '0, '0, '0, 1'b0, 1'b1, '0);
      idle("post_reset", 1);

      // Table vectors, each drained so out_valid lasts exactly one cycle.
      for (int i = 0; i < 13; i++) begin
         step(tbl[i].name, 1'b1, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].im,
              7'(i + 16), 1'b0, 1'b0, tbl[i].exp);
         idle("drain", STAGES);
      end
      // Borrow generate when rb >= ra.
      step("bg_eq", 1'b1, 4'h9, {4{32'h0000_0004}}, {4{32'h0000_0004}}, '0, 7'h12,
           1'b0, 1'b0, {4{CG_ONE}});
      idle("drain", STAGES);

      // Four back-to-back issues, tags 1..4.
      for (int i = 1; i <= 4; i++) begin
         ra_r = {4{32'(i * 100)}};
         step("b2b", 1'b1, 4'h1, ra_r, '0, 10'(i), 7'(i), 1'b0, 1'b0,
              model(4'h1, ra_r, '0, 10'(i)));
      end
      idle("b2b_drain", STAGES + 1);

      // Flush on the third issue cycle.
      emitted = 0;
      for (int i = 1; i <= 3; i++) begin
         ra_r = {4{32'(i)}};
         step("flush_seq", 1'b1, 4'h0, ra_r, ra_r, '0, 7'(32 + i), (i == 3), 1'b0,
              model(4'h0, ra_r, ra_r, '0));
      end
      idle("flush_drain", STAGES + 3);
      want = (STAGES == 2) ? 1 : 0;
      count_check("flush_count", want);

      // Reset for one edge with two ops in flight.
      emitted = 0;
      for (int i = 1; i <= 2; i++) begin
         ra_r = {4{32'(i + 7)}};
         step("rst_seq", 1'b1, 4'h2, ra_r, ra_r, '0, 7'(48 + i), 1'b0, 1'b0,
              model(4'h2, ra_r, ra_r, '0));
      end
      step("rst_mid", 1'b1, 4'h0, {4{32'h5}}, '0, '0, 7'h7F, 1'b0, 1'b1, '0);
      idle("rst_drain", STAGES + 3);
      want = (STAGES == 1) ? 2 : ((STAGES == 2) ? 1 : 0);
      count_check("rst_count", want);

      // Random traffic with occasional flushes.
      for (int n = 0; n < 300; n++) begin
         for (int w = 0; w < DW/32; w++) begin
            ra_r[32*w +: 32] = $urandom;
            rb_r[32*w +: 32] = $urandom;
         end
         if ($urandom_range(0, 3) == 0) rb_r[0 +: 32] = ra_r[0 +: 32];
         op_r = 4'($urandom_range(0, 15));
         im_r = 10'($urandom_range(0, 1023));
         step("rand", ($urandom_range(0, 3) != 0), op_r, ra_r, rb_r, im_r,
              7'($urandom_range(0, 127)), ($urandom_range(0, 24) == 0), 1'b0,
              model(op_r, ra_r, rb_r, im_r));
      end
      idle("rand_drain", STAGES + 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
